sort_float_triplet_stream: RTL and testbench

SORT_FLOAT_TRIPLET_STREAM -- requirements
Module: sort_float_triplet_stream

---
 rtl/sort_float_triplet_stream_if.sv | 25 ++
 rtl/sort_float_triplet_stream.sv | 157 +++++++++++++++
 tb/tb_sort_float_triplet_stream.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_float_triplet_stream_if.sv
// Handshake bundle for sort_float_triplet_stream: FP64 operand stream in, sorted
// operand stream out, plus the dropped-triplet pulse. The master modport is the sorter.
interface sort_float_triplet_stream_if;
    localparam int FLEN = 64;

    logic            up_valid;
    logic            up_ready;
    logic [FLEN-1:0] up_data;
    logic            down_valid;
    logic            down_ready;
    logic [FLEN-1:0] down_data;
    logic            down_last;
    logic            down_err;
    logic            err_drop;

    modport master (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_last, down_err, err_drop
    );

    modport slave (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_last, down_err, err_drop
    );
endinterface

// File: rtl/sort_float_triplet_stream.sv
// Collects three FP64 operands, sorts them ascending with one shared comparator over
// three bubble steps, then emits them. Optional macro: SORT_TRIPLET_ERR_DROP_EN.
module f_less_or_equal (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic        res_o,
    output logic        err_o
);
    logic aNan, bNan, aZero, bZero;

    assign aNan  = (&a_i[62:52]) && (|a_i[51:0]);
    assign bNan  = (&b_i[62:52]) && (|b_i[51:0]);
    assign aZero = ~(|a_i[62:0]);
    assign bZero = ~(|b_i[62:0]);

    // Sign-magnitude ordering; +0 and -0 compare equal, any NaN is unordered.
    always_comb begin
        res_o = 1'b0;
        err_o = 1'b0;
        if (aNan || bNan) begin
            err_o = 1'b1;
        end else if (aZero && bZero) begin
            res_o = 1'b1;
        end else if (a_i[63] != b_i[63]) begin
            res_o = a_i[63];
        end else if (!a_i[63]) begin
            res_o = (a_i[62:0] <= b_i[62:0]);
        end else begin
            res_o = (a_i[62:0] >= b_i[62:0]);
        end
    end
endmodule

module sort_float_triplet_stream (
    input  logic                       clk,
    input  logic                       rst,
    sort_float_triplet_stream_if.master bus
);
    localparam int FLEN = 64;

    typedef enum logic [1:0] {COLLECT, SORT, EMIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            errAcc_q, errAcc_d;
    logic            errDrop_q, errDrop_d;
    logic [FLEN-1:0] opBuf_q [3];
    logic [FLEN-1:0] opBuf_d [3];
    logic [FLEN-1:0] cmpA, cmpB;
    logic            cmpRes, cmpErr;

    // cnt doubles as the compare-step index while sorting: pairs (0,1), (1,2), (0,1).
    assign cmpA = (cnt_q == 2'd1) ? opBuf_q[1] : opBuf_q[0];
    assign cmpB = (cnt_q == 2'd1) ? opBuf_q[2] : opBuf_q[1];

    f_less_or_equal uCmp (
        .a_i   (cmpA),
        .b_i   (cmpB),
        .res_o (cmpRes),
        .err_o (cmpErr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        errAcc_d  = errAcc_q;
        errDrop_d = 1'b0;
        opBuf_d   = opBuf_q;
        unique case (state_q)
            COLLECT: begin
                if (bus.up_valid) begin
                    opBuf_d[cnt_q] = bus.up_data;
                    if (cnt_q == 2'd2) begin
                        cnt_d    = 2'd0;
                        errAcc_d = 1'b0;
                        state_d  = SORT;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            SORT: begin
                errAcc_d = errAcc_q | cmpErr;
                // Swap only on strict greater-than so equal keys keep arrival order.
                if (!cmpRes) begin
                    if (cnt_q == 2'd1) begin
                        opBuf_d[1] = opBuf_q[2];
                        opBuf_d[2] = opBuf_q[1];
                    end else begin
                        opBuf_d[0] = opBuf_q[1];
                        opBuf_d[1] = opBuf_q[0];
                    end
                end
                if (cnt_q == 2'd2) begin
                    cnt_d = 2'd0;
                    idx_d = 2'd0;
`ifdef SORT_TRIPLET_ERR_DROP_EN
                    if (errAcc_d) begin
                        state_d   = COLLECT;
                        errDrop_d = 1'b1;
                    end else begin
                        state_d = EMIT;
                    end
`else
                    state_d = EMIT;
`endif
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            EMIT: begin
                if (bus.down_ready) begin
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        state_d = COLLECT;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            cnt_q     <= 2'd0;
            idx_q     <= 2'd0;
            errAcc_q  <= 1'b0;
            errDrop_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                opBuf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            errAcc_q  <= errAcc_d;
            errDrop_q <= errDrop_d;
            opBuf_q   <= opBuf_d;
        end
    end

    assign bus.up_ready   = (state_q == COLLECT);
    assign bus.down_valid = (state_q == EMIT);
    assign bus.down_data  = (state_q == EMIT) ? opBuf_q[idx_q] : '0;
    assign bus.down_last  = (state_q == EMIT) && (idx_q == 2'd2);
`ifdef SORT_TRIPLET_ERR_DROP_EN
    assign bus.down_err   = 1'b0;
`else
    assign bus.down_err   = (state_q == EMIT) && errAcc_q;
`endif
    assign bus.err_drop   = errDrop_q;
endmodule

// File: tb/tb_sort_float_triplet_stream.sv
// Scoreboard bench for sort_float_triplet_stream: directed triplets push their sorted
// expectations into a queue; a negedge monitor pops and compares every output transfer.
module tb_sort_float_triplet_stream;
    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;
    localparam logic [63:0] THREE = 64'h4008000000000000;
    localparam logic [63:0] FIVE  = 64'h4014000000000000;
    localparam logic [63:0] SEVEN = 64'h401C000000000000;
    localparam logic [63:0] NEG1  = 64'hBFF0000000000000;
    localparam logic [63:0] PZ    = 64'h0000000000000000;
    localparam logic [63:0] NZ    = 64'h8000000000000000;
    localparam logic [63:0] QNAN  = 64'h7FF8000000000000;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        err;
    } expT;

    logic clk = 1'b0;
    logic rst;

    sort_float_triplet_stream_if bus ();

    sort_float_triplet_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int  checks        = 0;
    int  errors        = 0;
    int  cycle         = 0;
    int  errDropSeen   = 0;
    int  expDrops      = 0;
    int  firstAccCycle = 0;
    expT expQ[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [63:0] d, input logic last, input logic err);
        expT e;
        e.data = d;
        e.last = last;
        e.err  = err;
        expQ.push_back(e);
    endtask

    // Holds one operand on the bus until it is accepted; up_valid is left high.
    task automatic sendOperand(input logic [63:0] d, output int accCycle);
        bit accepted = 1'b0;
        bus.up_valid = 1'b1;
        bus.up_data  = d;
        accCycle     = -1;
        for (int t = 0; t < 40 && !accepted; t++) begin
            @(negedge clk);
            if (bus.up_ready) begin
                accepted = 1'b1;
                accCycle = cycle;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout operand=%h not accepted within 40 cycles", d);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] in0, input logic [63:0] in1, input logic [63:0] in2,
                                 input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2,
                                 input logic errExp);
        int c0, c1, c2;
`ifdef SORT_TRIPLET_ERR_DROP_EN
        if (errExp) begin
            expDrops++;
        end else begin
            pushExp(e0, 1'b0, 1'b0);
            pushExp(e1, 1'b0, 1'b0);
            pushExp(e2, 1'b1, 1'b0);
        end
`else
        pushExp(e0, 1'b0, errExp);
        pushExp(e1, 1'b0, errExp);
        pushExp(e2, 1'b1, errExp);
`endif
        sendOperand(in0, c0);
        firstAccCycle = c0;
        sendOperand(in1, c1);
        sendOperand(in2, c2);
    endtask

    task automatic waitIdle();
        bit idle = 1'b0;
        for (int t = 0; t < 60 && !idle; t++) begin
            @(negedge clk);
            idle = (expQ.size() == 0) && bus.up_ready;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout pending=%0d up_ready=%0b", expQ.size(), bus.up_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every down transfer against the queue head, watches idle flags and drop pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.down_valid && bus.down_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output actual=%h expected=none", bus.down_data);
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    checkOutput("down_data", bus.down_data, e.data);
                    checkOutput("down_last", 64'(bus.down_last), 64'(e.last));
                    checkOutput("down_err", 64'(bus.down_err), 64'(e.err));
                end
            end
            if (!bus.down_valid) begin
                checkOutput("idle_flags", 64'({bus.down_last, bus.down_err}), 64'd0);
            end
            if (bus.err_drop) begin
                errDropSeen++;
                checkOutput("drop_up_ready", 64'(bus.up_ready), 64'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  lat;
        int  a, b, c;
        bit  seen;

        rst            = 1'b1;
        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.down_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_up_ready", 64'(bus.up_ready), 64'd1);
        checkOutput("rst_down_valid", 64'(bus.down_valid), 64'd0);
        checkOutput("rst_down_data", bus.down_data, 64'd0);
        checkOutput("rst_down_last", 64'(bus.down_last), 64'd0);
        checkOutput("rst_down_err", 64'(bus.down_err), 64'd0);
        checkOutput("rst_err_drop", 64'(bus.err_drop), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic sort 3,1,2 with latency");
        applyStimulus(THREE, ONE, TWO, ONE, TWO, THREE, 1'b0);
        bus.up_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            lat++;
            seen = bus.down_valid;
        end
        checkOutput("latency", 64'(lat), 64'd4);
        waitIdle();

        $display("[TB] signed zeros keep arrival order");
        applyStimulus(NEG1, PZ, NZ, NEG1, PZ, NZ, 1'b0);
        bus.up_valid = 1'b0;
        waitIdle();

        $display("[TB] backpressure hold at idx 1");
        bus.down_ready = 1'b0;
        applyStimulus(THREE, TWO, ONE, ONE, TWO, THREE, 1'b0);
        bus.up_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = bus.down_valid;
        end
        checkOutput("stall_reach_emit", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        bus.down_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.down_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_valid", 64'(bus.down_valid), 64'd1);
            checkOutput("stall_data", bus.down_data, TWO);
            checkOutput("stall_last", 64'(bus.down_last), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.down_ready = 1'b1;
        waitIdle();

        $display("[TB] NaN triplet");
        applyStimulus(QNAN, ONE, TWO, ONE, TWO, QNAN, 1'b1);
        bus.up_valid = 1'b0;
        waitIdle();

        $display("[TB] reset after two operands");
        sendOperand(FIVE, c);
        sendOperand(SEVEN, c);
        bus.up_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_up_ready", 64'(bus.up_ready), 64'd1);
        checkOutput("midrst_down_valid", 64'(bus.down_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_down_valid", 64'(bus.down_valid), 64'd0);
        checkOutput("postrst_down_data", bus.down_data, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(TWO, TWO, ONE, ONE, TWO, TWO, 1'b0);
        bus.up_valid = 1'b0;
        waitIdle();

        $display("[TB] back-to-back triplets");
        applyStimulus(TWO, THREE, ONE, ONE, TWO, THREE, 1'b0);
        a = firstAccCycle;
        applyStimulus(SEVEN, FIVE, NEG1, NEG1, FIVE, SEVEN, 1'b0);
        b = firstAccCycle;
        bus.up_valid = 1'b0;
        checkOutput("b2b_period", 64'(b - a), 64'd9);
        waitIdle();

        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("err_drop_pulses", 64'(errDropSeen), 64'(expDrops));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
